// File: rtl/oc8051_cxrom_arb.sv
// oc8051_cxrom_arb: shares one combinational 32-bit code ROM between the CPU
// instruction-fetch path and the secure-boot (SB) ROM reader.
//
// Handshake: a requester raises req with a stable addr and holds both until
// its ack. ack is a one-cycle pulse and data is valid in that same cycle. A
// grant always completes, even if req drops before ack. Back-to-back requests
// keep req high and present the new addr during the ack (DONE) cycle.
//
// Each access takes three cycles: IDLE (arbitrate), ACCESS (ROM read), and
// DONE (ack). The CPU has priority. A saturating starvation counter forces
// an SB win after STARVE_MAX consecutive CPU grants while SB is waiting.
//
// Optional feature macro: CXROM_ARB_PROT_EN. When it is defined, a CPU read in
// [PROT_LO, PROT_HI] returns zero data with cpu_err and leaves the ROM address
// unchanged.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = ACCESS, 2 = DONE.
module oc8051_cxrom_arb #(
    parameter int          STARVE_MAX = 4,
    parameter logic [15:0] PROT_LO    = 16'hF000,
    parameter logic [15:0] PROT_HI    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_data,
    output logic        cpu_err,
    input  logic        sb_req,
    input  logic [15:0] sb_addr,
    output logic        sb_ack,
    output logic [31:0] sb_data,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        own_cpu_q, own_cpu_d;
    logic        own_sb_q, own_sb_d;
    logic        prot_q, prot_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] cpu_data_q, cpu_data_d;
    logic [31:0] sb_data_q, sb_data_d;
    logic        sb_wins;
    logic        cpu_prot;

`ifdef CXROM_ARB_PROT_EN
    assign cpu_prot = (cpu_addr >= PROT_LO) && (cpu_addr <= PROT_HI);
    assign cpu_err  = (state_q == DONE) && own_cpu_q && prot_q;
`else
    logic unused_prot_params;
    assign unused_prot_params = ^{PROT_LO, PROT_HI};
    assign cpu_prot = 1'b0;
    assign cpu_err  = 1'b0;
`endif

    // SB takes the grant when the CPU is idle or has starved SB long enough.
    assign sb_wins = sb_req && (!cpu_req || (starve_q == STARVE_LIM));

    // Next-state, grant bookkeeping and ROM data capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        own_cpu_d  = own_cpu_q;
        own_sb_d   = own_sb_q;
        prot_d     = prot_q;
        starve_d   = starve_q;
        cpu_data_d = cpu_data_q;
        sb_data_d  = sb_data_q;
        case (state_q)
            IDLE: begin
                if (!sb_req) begin
                    starve_d = 4'd0;
                end
                if (cpu_req || sb_req) begin
                    state_d = ACCESS;
                    if (sb_wins) begin
                        addr_d    = sb_addr;
                        own_sb_d  = 1'b1;
                        own_cpu_d = 1'b0;
                        prot_d    = 1'b0;
                        starve_d  = 4'd0;
                    end else begin
                        own_cpu_d = 1'b1;
                        own_sb_d  = 1'b0;
                        prot_d    = cpu_prot;
                        // A protected read never drives its address to the ROM.
                        if (!cpu_prot) begin
                            addr_d = cpu_addr;
                        end
                        if (sb_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (own_cpu_q) begin
                    cpu_data_d = prot_q ? 32'h0 : rom_data;
                end
                if (own_sb_q) begin
                    sb_data_d = rom_data;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= 16'h0;
            own_cpu_q  <= 1'b0;
            own_sb_q   <= 1'b0;
            prot_q     <= 1'b0;
            starve_q   <= 4'd0;
            cpu_data_q <= 32'h0;
            sb_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            own_cpu_q  <= own_cpu_d;
            own_sb_q   <= own_sb_d;
            prot_q     <= prot_d;
            starve_q   <= starve_d;
            cpu_data_q <= cpu_data_d;
            sb_data_q  <= sb_data_d;
        end
    end

    assign rom_addr  = addr_q;
    assign cpu_data  = cpu_data_q;
    assign sb_data   = sb_data_q;
    assign cpu_ack   = (state_q == DONE) && own_cpu_q;
    assign sb_ack    = (state_q == DONE) && own_sb_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Testbench for oc8051_cxrom_arb: directed vector table, reset-abort sequence,
// and randomized traffic against a transaction-level reference model.
module tb_oc8051_cxrom_arb;

    localparam int STARVE_MAX = 4;
    localparam int W_NONE = 0;
    localparam int W_CPU  = 1;
    localparam int W_SB   = 2;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [31:0] cpu_data;
    logic        cpu_err;
    logic        sb_req;
    logic [15:0] sb_addr;
    logic        sb_ack;
    logic [31:0] sb_data;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int          streak;
    logic [15:0] exp_rom_addr;
    logic [31:0] exp_cpu_data;
    logic [31:0] exp_sb_data;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        cr;
        logic [15:0] ca;
        logic        sr;
        logic [15:0] sa;
        int          win;
    } vec_t;

    vec_t vecs[18];

    oc8051_cxrom_arb #(
        .STARVE_MAX(STARVE_MAX),
        .PROT_LO   (16'hF000),
        .PROT_HI   (16'hFFFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_ack  (cpu_ack),
        .cpu_data (cpu_data),
        .cpu_err  (cpu_err),
        .sb_req   (sb_req),
        .sb_addr  (sb_addr),
        .sb_ack   (sb_ack),
        .sb_data  (sb_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .state_dbg(state_dbg)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ROM contents: a fixed scramble of the address.
    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, {a[7:0], a[15:8]} + 16'h1357};
    endfunction

    assign rom_data = rom_word(rom_addr);

    function automatic logic is_prot(input logic [15:0] a);
`ifdef CXROM_ARB_PROT_EN
        return (a >= 16'hF000);
`else
        return (a != a);
`endif
    endfunction

    // Arbitration rule from the requester's point of view.
    function automatic int pick(input logic cr, input logic sr);
        if (!cr && !sr) return W_NONE;
        if (sr && (!cr || streak >= STARVE_MAX)) return W_SB;
        return W_CPU;
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
        return 16'($urandom_range(0, 16'hFFFF));
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        streak       = 0;
        exp_rom_addr = 16'h0;
        exp_cpu_data = 32'h0;
        exp_sb_data  = 32'h0;
        exp_q.delete();
    endtask

    // One arbitration slot, entered and left at the negedge of an IDLE cycle.
    task automatic run_slot(input logic cr, input logic [15:0] ca, input logic sr,
                            input logic [15:0] sa, input int win, input string tag);
        logic        prot;
        logic [31:0] word;
        cpu_req  = cr;
        cpu_addr = ca;
        sb_req   = sr;
        sb_addr  = sa;
        if (!sr) streak = 0;
        if (win == W_SB) streak = 0;
        else if (win == W_CPU && sr) streak++;
        @(posedge clk);
        @(negedge clk);
        if (win == W_NONE) begin
            chk({tag, "_idle_acks"}, {61'd0, cpu_ack, sb_ack, cpu_err}, 64'd0);
            return;
        end
        prot = (win == W_CPU) && is_prot(ca);
        if (!prot) exp_rom_addr = (win == W_CPU) ? ca : sa;
        exp_q.push_back(prot ? 32'h0 : rom_word(exp_rom_addr));
        chk({tag, "_access_rom_addr"}, {48'd0, rom_addr}, {48'd0, exp_rom_addr});
        chk({tag, "_access_acks"}, {61'd0, cpu_ack, sb_ack, cpu_err}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        word = exp_q.pop_front();
        if (win == W_CPU) exp_cpu_data = word;
        else exp_sb_data = word;
        chk({tag, "_done_acks"}, {61'd0, cpu_ack, sb_ack, cpu_err},
            {61'd0, (win == W_CPU), (win == W_SB), prot});
        chk({tag, "_cpu_data"}, {32'd0, cpu_data}, {32'd0, exp_cpu_data});
        chk({tag, "_sb_data"}, {32'd0, sb_data}, {32'd0, exp_sb_data});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_after_acks"}, {61'd0, cpu_ack, sb_ack, cpu_err}, 64'd0);
    endtask

    initial begin
        logic        cpu_pend;
        logic        sb_pend;
        logic [15:0] cpu_pa;
        logic [15:0] sb_pa;
        int          win;

        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, W_CPU};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, W_SB};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0104, W_SB};
        vecs[3]  = '{1'b1, 16'h0020, 1'b1, 16'h0200, W_CPU};
        vecs[4]  = '{1'b1, 16'h0024, 1'b1, 16'h0200, W_CPU};
        vecs[5]  = '{1'b1, 16'h0028, 1'b1, 16'h0200, W_CPU};
        vecs[6]  = '{1'b1, 16'h002C, 1'b1, 16'h0200, W_CPU};
        vecs[7]  = '{1'b1, 16'h0030, 1'b1, 16'h0200, W_SB};
        vecs[8]  = '{1'b1, 16'h0030, 1'b1, 16'h0204, W_CPU};
        vecs[9]  = '{1'b1, 16'h0034, 1'b1, 16'h0204, W_CPU};
        vecs[10] = '{1'b1, 16'h0038, 1'b1, 16'h0204, W_CPU};
        vecs[11] = '{1'b1, 16'h003C, 1'b1, 16'h0204, W_CPU};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, W_NONE};
        vecs[13] = '{1'b1, 16'h0044, 1'b1, 16'h0300, W_CPU};
        vecs[14] = '{1'b1, 16'hF004, 1'b1, 16'h0300, W_CPU};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 16'h0300, W_SB};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 16'hF004, W_SB};
        vecs[17] = '{1'b1, 16'h0050, 1'b0, 16'h0000, W_CPU};

        // Reset held for two edges: every output must be zero.
        rst      = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = 16'h0;
        sb_req   = 1'b0;
        sb_addr  = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rom_addr", {48'd0, rom_addr}, 64'd0);
        chk("reset_cpu_data", {32'd0, cpu_data}, 64'd0);
        chk("reset_sb_data", {32'd0, sb_data}, 64'd0);
        chk("reset_acks", {61'd0, cpu_ack, sb_ack, cpu_err}, 64'd0);
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            run_slot(vecs[i].cr, vecs[i].ca, vecs[i].sr, vecs[i].sa, vecs[i].win,
                     $sformatf("vec%0d", i));
        end

        // Reset during ACCESS drops the read; the re-issued read completes.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0040;
        sb_req   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_access_rom_addr", {48'd0, rom_addr}, 64'h0040);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_acks", {61'd0, cpu_ack, sb_ack, cpu_err}, 64'd0);
        chk("rstmid_cpu_data", {32'd0, cpu_data}, 64'd0);
        chk("rstmid_sb_data", {32'd0, sb_data}, 64'd0);
        chk("rstmid_rom_addr", {48'd0, rom_addr}, 64'd0);
        chk("rstmid_state_idle", {62'd0, state_dbg}, 64'd0);
        rst = 1'b1;
        model_reset();
        run_slot(1'b1, 16'h0040, 1'b0, 16'h0000, W_CPU, "rst_reissue");

        // Randomized traffic; a losing requester holds its request until served.
        cpu_pend = 1'b0;
        sb_pend  = 1'b0;
        cpu_pa   = 16'h0;
        sb_pa    = 16'h0;
        for (int n = 0; n < 240; n++) begin
            if (!cpu_pend && $urandom_range(0, 2) != 0) begin
                cpu_pend = 1'b1;
                cpu_pa   = rand_addr();
            end
            if (!sb_pend && $urandom_range(0, 2) == 0) begin
                sb_pend = 1'b1;
                sb_pa   = rand_addr();
            end
            win = pick(cpu_pend, sb_pend);
            run_slot(cpu_pend, cpu_pa, sb_pend, sb_pa, win, "rnd");
            if (win == W_CPU) cpu_pend = 1'b0;
            else if (win == W_SB) sb_pend = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oc8051_cxrom_arb.md
Name: oc8051_cxrom_arb

Overview:
Arbiter and sequencer that shares the single fully-combinational 32-bit code ROM between two requesters. The requesters are the oc8051 instruction-fetch path (CPU) and the secure-boot ROM reader (SB), which hashes ROM contents.
- Each requester sees a req/ack handshake with registered read data.
- The arbiter drives the ROM address from a registered latch and captures ROM data into a per-port output register.
- CPU has priority; a starvation counter guarantees SB forward progress.

Parameters:
STARVE_MAX, 4, consecutive CPU grants allowed while sb_req is pending before SB is forced to win; legal 1..15
PROT_LO, 16'hF000, lowest protected ROM address; used only with the optional feature
PROT_HI, 16'hFFFF, highest protected ROM address, inclusive; used only with the optional feature

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk
cpu_req  input  1  CPU read request; held high with cpu_addr stable until cpu_ack
cpu_addr  input  16  CPU read address
cpu_ack  output  1  one-cycle pulse; cpu_data valid in the same cycle
cpu_data  output  32  registered CPU read data
cpu_err  output  1  one-cycle pulse with cpu_ack for a protected access; constant 0 without the feature
sb_req  input  1  SB read request; same rules as cpu_req
sb_addr  input  16  SB read address
sb_ack  output  1  one-cycle pulse; sb_data valid in the same cycle
sb_data  output  32  registered SB read data
rom_addr  output  16  address to ROM; driven from registered addr_q
rom_data  input  32  combinational ROM data for rom_addr

Behaviour:
- Reset (rst==0 at clock edge), including mid-transaction:
  - State goes to IDLE.
  - addr_q, rom_addr, cpu_data and sb_data go to 0.
  - cpu_ack, sb_ack and cpu_err go to 0.
  - Starvation counter goes to 0 and the grant owner is cleared.
  - An in-flight transaction is dropped with no ack; the requester re-issues it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select the winner, latch its address into addr_q and record the owner, then go to ACCESS.
  - Winner rule:
    - SB wins if sb_req && (!cpu_req || starve_cnt == STARVE_MAX).
    - Otherwise CPU wins.
- ACCESS:
  - rom_addr = addr_q.
  - On the clock edge, rom_data is captured into the owner's data register. The other port's data register holds its value.
  - Next state is DONE.
- DONE:
  - Owner's ack = 1 for exactly this cycle.
  - Next state is IDLE; no arbitration happens in DONE.
  - Requester may keep req high to issue a back-to-back request. It must change addr in the DONE cycle if a new address is wanted.
- Timing:
  - Latency is 2 cycles from the grant edge to ack.
  - Throughput is one transaction per 3 cycles.
  - rom_addr holds its last value when no transaction is in progress.
- Starvation counter (4-bit):
  - Increments on each CPU grant made while sb_req is high.
  - Clears on an SB grant, or in any IDLE cycle with sb_req low.
  - Saturates at STARVE_MAX.
- Requester dropping req before its ack: the transaction still completes and ack still pulses; the requester ignores it.
- A req without a grant must not produce an ack. Acks never overlap: at most one of cpu_ack/sb_ack is high in any cycle.

Optional Feature:
Macro: CXROM_ARB_PROT_EN.
- When defined, in IDLE a CPU grant with PROT_LO <= cpu_addr <= PROT_HI is marked protected. It follows the same FSM timing as a normal grant, except:
  - ACCESS does not update addr_q or rom_addr; the previous value is held.
  - cpu_data is loaded with 32'h0.
  - In DONE, cpu_err = 1 together with cpu_ack.
  - SB accesses are never checked.
- When not defined:
  - No range check; PROT_LO and PROT_HI are unused.
  - cpu_err is tied to 0.

Test Plan:
1. Hold rst=0 for 2 cycles -> all outputs 0. Release rst, then cpu_req=1, cpu_addr=16'h0010 -> rom_addr=16'h0010 one cycle after grant; cpu_ack high 2 cycles after grant; cpu_data equals ROM word at 16'h0010; sb_ack stays 0.
2. cpu_req and sb_req both high continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,SB,CPU,...; every grant has 3-cycle spacing; acks never overlap.
3. sb_req alone, sb_addr=16'h0100 then 16'h0104 back-to-back -> two sb_ack pulses 3 cycles apart; sb_data carries the matching ROM words; cpu_data unchanged.
4. Assert rst=0 in the ACCESS cycle of a CPU read -> no cpu_ack. The cycle after rst returns high, state is IDLE with cpu_data=0. Re-request completes normally.
5. With CXROM_ARB_PROT_EN, cpu_addr=16'hF004 -> cpu_ack with cpu_err=1, cpu_data=32'h0, rom_addr unchanged. sb_addr=16'hF004 -> sb_ack with real ROM data.
6. Without CXROM_ARB_PROT_EN, cpu_addr=16'hF004 -> cpu_ack with real ROM data; cpu_err stays 0 throughout.
